// File: rtl/vga_dbuf_ctrl.sv
// vga_dbuf_ctrl: double-buffered frame store for the VGA path.
// The drawing engine writes the back bank while the scan reads the front bank.
// Swap requests are latched and serviced only on frame_start, so the displayed
// frame never tears. With CLEAR_ON_SWAP=1 the new back bank is filled with
// CLEAR_COLOR after every swap, one pixel per cycle.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   wr_en, wr_x, wr_y, wr_data  pixel write into the back bank
//   wr_ready                    back bank accepts writes (low while clearing)
//   swap_req                    pulse: request a buffer swap
//   frame_start                 pulse: start of vertical blank
//   swap_pending                request latched, waiting for frame_start
//   swap_done                   pulse, the cycle after front_sel toggles
//   front_sel                   bank currently displayed
//   rd_en, rd_x, rd_y, rd_data  registered read from the front bank
module vga_dbuf_ctrl #(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int PIXEL_SIZE    = 8,
    parameter int CLEAR_ON_SWAP = 0,
    parameter logic [PIXEL_SIZE-1:0] CLEAR_COLOR = '0,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH*HEIGHT)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [XW-1:0]         wr_x,
    input  logic [YW-1:0]         wr_y,
    input  logic [PIXEL_SIZE-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  swap_req,
    input  logic                  frame_start,
    output logic                  swap_pending,
    output logic                  swap_done,
    output logic                  front_sel,
    input  logic                  rd_en,
    input  logic [XW-1:0]         rd_x,
    input  logic [YW-1:0]         rd_y,
    output logic [PIXEL_SIZE-1:0] rd_data
);

    localparam int NPIX = WIDTH*HEIGHT;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [AW-1:0]         clr_cnt;
    logic                  swap_evt;

    logic [PIXEL_SIZE-1:0] bank0 [NPIX];
    logic [PIXEL_SIZE-1:0] bank1 [NPIX];

    logic                  wr_ok, rd_ok, swap_take;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic                  mem_we, mem_bank;
    logic [AW-1:0]         mem_addr;
    logic [PIXEL_SIZE-1:0] mem_wdata;

    assign wr_ok   = wr_en && wr_ready && (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign rd_ok   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
    assign wr_addr = AW'(32'(wr_y) * WIDTH + 32'(wr_x));
    assign rd_addr = AW'(32'(rd_y) * WIDTH + 32'(rd_x));

    // A request arriving together with frame_start is serviced immediately,
    // so swap_pending never rises for it.
    assign swap_take = (state == IDLE) && frame_start && (swap_pending || swap_req);

    // Single write port into the back bank: the clear sequencer owns it while
    // clearing (wr_ready is low then, so no user write competes). Using the
    // pre-edge front_sel sends a write coincident with a swap to the old back
    // bank, which is the one about to be displayed.
    always_comb begin
        mem_we    = wr_ok;
        mem_bank  = ~front_sel;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = CLEAR_COLOR;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mem_bank) bank1[mem_addr] <= mem_wdata;
            else          bank0[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (!rd_ok)        rd_data <= '0;
            else if (front_sel) rd_data <= bank1[rd_addr];
            else               rd_data <= bank0[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_evt     <= 1'b0;
            swap_done    <= 1'b0;
            wr_ready     <= 1'b1;
        end else begin
            // swap_done trails the front_sel toggle by one cycle
            swap_evt  <= 1'b0;
            swap_done <= swap_evt;
            case (state)
                IDLE: begin
                    if (swap_take) begin
                        front_sel    <= ~front_sel;
                        swap_pending <= 1'b0;
                        swap_evt     <= 1'b1;
                        if (CLEAR_ON_SWAP != 0) begin
                            state    <= CLEAR;
                            clr_cnt  <= '0;
                            wr_ready <= 1'b0;
                        end
                    end else if (swap_req) begin
                        swap_pending <= 1'b1;
                    end
                end
                CLEAR: begin
                    // frame_start is ignored here; a pending request waits
                    // for the first frame_start after the clear.
                    if (swap_req) swap_pending <= 1'b1;
                    if (clr_cnt == AW'(NPIX-1)) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_dbuf_ctrl.sv
module tb_vga_dbuf_ctrl;

    localparam int W = 4, H = 3, P = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         wr_en = 1'b0, swap_req = 1'b0, frame_start = 1'b0, rd_en = 1'b0;
    logic [1:0]   wr_x = '0, wr_y = '0, rd_x = '0, rd_y = '0;
    logic [P-1:0] wr_data = '0;

    logic         rdy0, pend0, done0, front0;
    logic [P-1:0] rd0;
    logic         rdy1, pend1, done1, front1;
    logic [P-1:0] rd1;

    // dut0: plain double buffer; dut1: clear-on-swap with colour 0x3C
    vga_dbuf_ctrl #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(P), .CLEAR_ON_SWAP(0), .CLEAR_COLOR(8'h00)) dut0 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ready(rdy0), .swap_req(swap_req), .frame_start(frame_start), .swap_pending(pend0),
        .swap_done(done0), .front_sel(front0), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd0));

    vga_dbuf_ctrl #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(P), .CLEAR_ON_SWAP(1), .CLEAR_COLOR(8'h3C)) dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ready(rdy1), .swap_req(swap_req), .frame_start(frame_start), .swap_pending(pend1),
        .swap_done(done1), .front_sel(front1), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd1));

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        int we, x, y, d;
        int sr, fs;
        int re, rx, ry;
        int chk_rd, e_rd;
        int e_front, e_done;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input int d);
        wr_en = 1'b1; wr_x = 2'(x); wr_y = 2'(y); wr_data = 8'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int x, input int y);
        rd_en = 1'b1; rd_x = 2'(x); rd_y = 2'(y);
        step();
        rd_en = 1'b0;
    endtask

    task automatic swap_now();
        swap_req = 1'b1; frame_start = 1'b1;
        step();
        swap_req = 1'b0; frame_start = 1'b0;
    endtask

    // waits (bounded) for dut1 to leave its clear; returns wr_ready-low samples seen
    task automatic wait_clear(input int start_lo, output int lo);
        lo = start_lo;
        for (int i = 0; i < 40 && rdy1 == 1'b0; i++) begin
            step();
            if (rdy1 == 1'b0) lo++;
        end
    endtask

    initial begin
        int lo;
        //          we x y d      sr fs re rx ry chk rd     f  done
        tbl[0]  = '{1, 1, 2, 'hA5, 0, 0, 0, 0, 0, 0, 0,     0, 0};
        tbl[1]  = '{0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0,     1, 0};
        tbl[2]  = '{0, 0, 0, 0,    0, 0, 1, 1, 2, 1, 'hA5,  1, 1};
        tbl[3]  = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0,     1, 0};
        tbl[4]  = '{1, 0, 0, 'h11, 0, 0, 0, 0, 0, 0, 0,     1, 0};
        tbl[5]  = '{0, 0, 0, 0,    0, 0, 1, 0, 0, 1, 'h50,  1, 0};
        tbl[6]  = '{1, 0, 3, 'h22, 0, 0, 0, 0, 0, 0, 0,     1, 0};
        tbl[7]  = '{1, 3, 3, 'h22, 0, 0, 0, 0, 0, 0, 0,     1, 0};
        tbl[8]  = '{0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0,     0, 0};
        tbl[9]  = '{0, 0, 0, 0,    0, 0, 1, 0, 0, 1, 'h11,  0, 1};
        tbl[10] = '{0, 0, 0, 0,    0, 0, 1, 3, 2, 1, 'h6B,  0, 0};
        tbl[11] = '{0, 0, 0, 0,    0, 0, 1, 0, 3, 1, 0,     0, 0};
        tbl[12] = '{0, 0, 0, 0,    0, 0, 1, 1, 1, 1, 'h65,  0, 0};
        tbl[13] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 'h65,  0, 0};
        tbl[14] = '{0, 0, 0, 0,    1, 1, 1, 1, 1, 1, 'h65,  1, 0};
        tbl[15] = '{0, 0, 0, 0,    0, 0, 1, 1, 1, 1, 'h55,  1, 1};
        tbl[16] = '{1, 2, 0, 'h77, 1, 1, 0, 0, 0, 0, 0,     0, 0};
        tbl[17] = '{0, 0, 0, 0,    0, 0, 1, 2, 0, 1, 'h77,  0, 1};

        // reset state
        step(); step();
        chk("rst_front", 32'(front0), 32'd0);
        chk("rst_pend",  32'(pend0),  32'd0);
        chk("rst_done",  32'(done0),  32'd0);
        chk("rst_rdy",   32'(rdy0),   32'd1);
        chk("rst_rd",    32'(rd0),    32'd0);
        resetn = 1'b1;
        step();

        // preload dut0: bank1 = 0x50+i, bank0 = 0x60+i (i = y*4+x)
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) wr(x, y, 'h50 + y*W + x);
        swap_now();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) wr(x, y, 'h60 + y*W + x);
        swap_now();
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("rst2_front", 32'(front0), 32'd0);

        // table: swaps, write/read routing, range drops, coincident events
        for (int i = 0; i < 18; i++) begin
            wr_en = (tbl[i].we != 0); wr_x = 2'(tbl[i].x); wr_y = 2'(tbl[i].y); wr_data = 8'(tbl[i].d);
            swap_req = (tbl[i].sr != 0); frame_start = (tbl[i].fs != 0);
            rd_en = (tbl[i].re != 0); rd_x = 2'(tbl[i].rx); rd_y = 2'(tbl[i].ry);
            step();
            if (tbl[i].chk_rd != 0) chk($sformatf("vec%0d_rd", i), 32'(rd0), 32'(tbl[i].e_rd));
            chk($sformatf("vec%0d_front", i), 32'(front0), 32'(tbl[i].e_front));
            chk($sformatf("vec%0d_done", i), 32'(done0), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_pend", i), 32'(pend0), 32'd0);
            chk($sformatf("vec%0d_rdy", i), 32'(rdy0), 32'd1);
        end
        wr_en = 1'b0; swap_req = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
        step();

        // deferred swap: request latched, serviced ten cycles later
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("pend_c%0d", i), 32'(pend0), 32'd1);
            chk($sformatf("hold_c%0d", i), 32'(front0), 32'd0);
            if (i == 4) swap_req = 1'b1;   // repeat request is idempotent
            step();
            swap_req = 1'b0;
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("defer_front", 32'(front0), 32'd1);
        chk("defer_pend",  32'(pend0),  32'd0);
        chk("defer_done0", 32'(done0),  32'd0);
        step();
        chk("defer_done1", 32'(done0),  32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("nopend_front", 32'(front0), 32'd1);
        chk("done_single",  32'(done0),  32'd0);

        // clear-on-swap: 12-cycle window, writes dropped, both banks cleared
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        swap_now();
        chk("clr1_front", 32'(front1), 32'd1);
        chk("clr1_rdy",   32'(rdy1),   32'd0);
        wr_en = 1'b1; wr_x = 2'd0; wr_y = 2'd0; wr_data = 8'h99;
        wait_clear(1, lo);
        wr_en = 1'b0;
        chk("clr1_len", 32'(lo), 32'd12);
        swap_now();
        chk("clr2_front", 32'(front1), 32'd0);
        wait_clear(1, lo);
        chk("clr2_len", 32'(lo), 32'd12);
        for (int i = 0; i < W*H; i++) begin
            rd(i % W, i / W);
            chk($sformatf("clr_px%0d", i), 32'(rd1), 32'h3C);
        end
        wr(2, 1, 'h42);
        swap_now();
        rd(2, 1);
        chk("post_clr_wr", 32'(rd1), 32'h42);

        // frame_start during clear is ignored; pending survives
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("clr_pend", 32'(pend1), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("clr_notgl", 32'(front1), 32'd1);
        chk("clr_pend2", 32'(pend1),  32'd1);
        wait_clear(0, lo);
        chk("clr3_done", 32'(rdy1), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("after_clr_tgl",  32'(front1), 32'd0);
        chk("after_clr_pend", 32'(pend1),  32'd0);

        // asynchronous reset in the middle of a clear
        step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("pre_rst_rdy", 32'(rdy1), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_front", 32'(front1), 32'd0);
        chk("arst_rdy",   32'(rdy1),   32'd1);
        chk("arst_pend",  32'(pend1),  32'd0);
        chk("arst_rd",    32'(rd1),    32'd0);
        step();
        resetn = 1'b1;
        step();
        wr(1, 0, 'h5A);
        swap_now();
        chk("arst_swap", 32'(front1), 32'd1);
        rd(1, 0);
        chk("arst_wr", 32'(rd1), 32'h5A);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
